// File: rtl/simon_pkt_unpack.sv
// simon_pkt_unpack: validates host byte packets and routes keys to a holding register and blocks to a FIFO
module simon_pkt_unpack #(
  parameter int         N     = 16,
  parameter int         M     = 4,
  parameter int         DEPTH = 4,
  parameter logic [3:0] MODE  = 4'd0
) (
  input  logic                   clk,
  input  logic                   nR,
  input  logic                   in_valid,
  input  logic [(N/2+2)*8-1:0]   in,
  output logic                   in_ready,
  output logic                   blk_valid,
  input  logic                   blk_ready,
  output logic [1:0][N-1:0]      blk_data,
  output logic [7:0]             blk_info,
  output logic [$clog2(DEPTH):0] blk_level,
  output logic                   key_valid,
  input  logic                   key_ready,
  output logic [M-1:0][N-1:0]    KEY,
  output logic                   err,
  output logic [1:0]             err_code,
  output logic [7:0]             err_total,
  output logic                   busy
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [2:0] {IDLE, CHECK, BLK_A, BLK_B, KEY_WAIT} state_t;
  state_t            state, next;
  logic [3:0][N-1:0] pkt_w;
  logic [7:0]        pkt_cnt, pkt_info, exp_cnt;
  logic [2*N-1:0]    mem_d [DEPTH];
  logic [7:0]        mem_i [DEPTH];
  logic [AW-1:0]     wp, rp;
  logic [1:0]        code;
  logic              full, push, pop, key_load;
  logic [2*N-1:0]    push_d;
  assign in_ready  = state == IDLE;
  assign busy      = state != IDLE;
  assign full      = blk_level == (AW+1)'(DEPTH);
  assign blk_valid = blk_level != '0;
  assign pop       = blk_valid && blk_ready;
  assign blk_data  = mem_d[rp];
  assign blk_info  = mem_i[rp];
  // Error priority, FIFO push gating and key-load permission, then next state
  always_comb begin
    code     = pkt_cnt != exp_cnt ? 2'd1 : pkt_info[3:0] != MODE ? 2'd2 : pkt_info[4] ? 2'd3 : 2'd0;
    push     = (state == BLK_A || state == BLK_B) && !full;
    push_d   = state == BLK_A ? {pkt_w[0], pkt_w[1]} : {pkt_w[2], pkt_w[3]};
    key_load = state == KEY_WAIT && !blk_valid && (!key_valid || key_ready);
    next     = state;
    case (state)
      IDLE:     next = in_valid ? CHECK : IDLE;
      CHECK:    next = code != 2'd0 ? IDLE : pkt_info[5] ? KEY_WAIT : pkt_info[7] ? BLK_A : BLK_B;
      BLK_A:    next = full ? BLK_A : BLK_B;
      BLK_B:    next = full ? BLK_B : IDLE;
      KEY_WAIT: next = key_load ? IDLE : KEY_WAIT;
      default:  next = IDLE;
    endcase
  end
  // State register, captured packet and sequence/error bookkeeping
  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      state     <= IDLE;
      pkt_w     <= '0;
      pkt_cnt   <= '0;
      pkt_info  <= '0;
      exp_cnt   <= '0;
      err       <= 1'b0;
      err_code  <= '0;
      err_total <= '0;
    end else begin
      state <= next;
      err   <= state == CHECK && code != 2'd0;
      if (state == IDLE && in_valid) begin
        pkt_w    <= in[4*N-1:0];
        pkt_cnt  <= in[4*N +: 8];
        pkt_info <= in[4*N+8 +: 8];
      end
      if (state == CHECK && code != 2'd0) begin
        err_code  <= code;
        err_total <= err_total == 8'hFF ? err_total : err_total + 8'd1;
      end
      if (state == CHECK && code == 2'd0)
        exp_cnt <= exp_cnt + 8'd1;
    end
  end
  // Block FIFO: storage, pointers and occupancy; a full FIFO refuses pushes even during a pop
  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i] <= '0;
        mem_i[i] <= '0;
      end
      wp        <= '0;
      rp        <= '0;
      blk_level <= '0;
    end else begin
      if (push) begin
        mem_d[wp] <= push_d;
        mem_i[wp] <= pkt_info;
        wp        <= wp + AW'(1);
      end
      if (pop)
        rp <= rp + AW'(1);
      blk_level <= blk_level + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  // Key holding register; a reload in the same cycle as a consume keeps key_valid high
  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      KEY       <= '0;
      key_valid <= 1'b0;
    end else begin
      if (key_load)
        KEY <= pkt_w[M-1:0];
      key_valid <= key_load ? 1'b1 : key_valid && key_ready ? 1'b0 : key_valid;
    end
  end
endmodule

// File: tb/tb_simon_pkt_unpack.sv
// tb_simon_pkt_unpack: directed packets with a block scoreboard checked by an independent monitor
module tb_simon_pkt_unpack;
  localparam int N = 16, M = 4, DEPTH = 4;
  logic                   clk = 0, nR = 0, in_valid = 0, blk_ready = 0, key_ready = 0;
  logic [(N/2+2)*8-1:0]   pkt_in = '0;
  logic                   in_ready, blk_valid, key_valid, err, busy;
  logic [1:0][N-1:0]      blk_data;
  logic [7:0]             blk_info, err_total;
  logic [$clog2(DEPTH):0] blk_level;
  logic [M-1:0][N-1:0]    key;
  logic [1:0]             err_code;
  logic [2*N+7:0]         q[$];
  logic [2*N+7:0]         exp_blk;
  int                     pass_cnt = 0, total_cnt = 0;

  simon_pkt_unpack #(.N(N), .M(M), .DEPTH(DEPTH), .MODE(4'd0)) dut (
    .clk(clk), .nR(nR), .in_valid(in_valid), .in(pkt_in), .in_ready(in_ready),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data), .blk_info(blk_info),
    .blk_level(blk_level), .key_valid(key_valid), .key_ready(key_ready), .KEY(key),
    .err(err), .err_code(err_code), .err_total(err_total), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic timeout(input string nm);
    total_cnt++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [N-1:0] w0, w1, w2, w3, input logic [7:0] c, inf, input bit good);
    int g = 0;
    pkt_in   = {inf, c, w3, w2, w1, w0};
    in_valid = 1;
    while (!in_ready && g < 200) begin tick(); g++; end
    if (g >= 200) timeout("send");
    tick();
    in_valid = 0;
    if (good && !inf[5]) begin
      if (inf[7]) q.push_back({inf, w0, w1});
      q.push_back({inf, w2, w3});
    end
  endtask

  task automatic settle(input string nm);
    int g = 0;
    while ((busy || blk_level != 0) && g < 300) begin tick(); g++; end
    if (g >= 300) timeout(nm);
    chk({nm, "_q_empty"}, q.size(), 0);
  endtask

  task automatic reset_vals(input string nm);
    chk({nm, "_in_ready"}, in_ready, 1);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_blk_valid"}, blk_valid, 0);
    chk({nm, "_blk_level"}, blk_level, 0);
    chk({nm, "_blk_data"}, blk_data, 0);
    chk({nm, "_blk_info"}, blk_info, 0);
    chk({nm, "_key_valid"}, key_valid, 0);
    chk({nm, "_key"}, key, 0);
    chk({nm, "_err"}, err, 0);
    chk({nm, "_err_code"}, err_code, 0);
    chk({nm, "_err_total"}, err_total, 0);
  endtask

  // Monitor: every block popped must match the head of the scoreboard
  always @(negedge clk) begin
    if (blk_valid && blk_ready) begin
      if (q.size() == 0) begin
        total_cnt++;
        $display("FAIL blk_unexpected: got %0h with no block expected", {blk_info, blk_data});
      end else begin
        exp_blk = q.pop_front();
        chk("blk_pop", {blk_info, blk_data}, exp_blk);
      end
    end
  end

  initial begin
    tick(); tick();
    reset_vals("reset");
    nR = 1;
    tick();

    // key packet, count 0
    send(16'h1111, 16'h2222, 16'h3333, 16'h4444, 8'd0, 8'h20, 1);
    chk("key_busy", busy, 1);
    chk("key_in_ready", in_ready, 0);
    tick();
    chk("key_valid_t1", key_valid, 0);
    tick();
    chk("key_valid_t2", key_valid, 1);
    chk("key_value", key, 64'h4444_3333_2222_1111);
    chk("key_idle", busy, 0);

    // two-block packet, count 1, key stays unconsumed
    send(16'hA000, 16'hA001, 16'hA002, 16'hA003, 8'd1, 8'h80, 1);
    tick(); tick();
    chk("two_level1", blk_level, 1);
    tick();
    chk("two_level2", blk_level, 2);
    chk("two_info", blk_info, 8'h80);
    chk("two_head", blk_data, 32'hA000_A001);
    blk_ready = 1;
    tick(); tick();
    blk_ready = 0;
    chk("two_drained", blk_level, 0);

    // count mismatch then recovery with the expected count
    send(16'hBAD0, 16'hBAD1, 16'hBAD2, 16'hBAD3, 8'd5, 8'h00, 0);
    tick();
    chk("cnt_err", err, 1);
    chk("cnt_code", err_code, 1);
    chk("cnt_total", err_total, 1);
    chk("cnt_in_ready", in_ready, 1);
    tick();
    chk("cnt_err_pulse", err, 0);
    chk("cnt_code_held", err_code, 1);
    chk("cnt_no_push", blk_level, 0);
    blk_ready = 1;
    send(16'hB000, 16'hB001, 16'hB002, 16'hB003, 8'd2, 8'h00, 1);
    settle("recover");

    // mode, direction and combined errors
    send(16'h0, 16'h0, 16'h0, 16'h0, 8'd3, 8'h03, 0);
    tick();
    chk("mode_code", err_code, 2);
    chk("mode_total", err_total, 2);
    send(16'h0, 16'h0, 16'h0, 16'h0, 8'd3, 8'h10, 0);
    tick();
    chk("dir_code", err_code, 3);
    chk("dir_total", err_total, 3);
    send(16'h0, 16'h0, 16'h0, 16'h0, 8'd9, 8'h05, 0);
    tick();
    chk("both_code", err_code, 1);
    chk("both_total", err_total, 4);
    settle("errs");

    // fill the FIFO and stall the third two-block packet
    blk_ready = 0;
    send(16'hC000, 16'hC001, 16'hC002, 16'hC003, 8'd3, 8'h80, 1);
    send(16'hC100, 16'hC101, 16'hC102, 16'hC103, 8'd4, 8'h80, 1);
    send(16'hC200, 16'hC201, 16'hC202, 16'hC203, 8'd5, 8'h80, 1);
    repeat (4) tick();
    chk("stall_level", blk_level, 4);
    chk("stall_busy", busy, 1);
    chk("stall_in_ready", in_ready, 0);
    blk_ready = 1;
    tick();
    blk_ready = 0;
    chk("pop_no_push", blk_level, 3);
    tick();
    chk("push_after_pop", blk_level, 4);
    tick(); tick();
    chk("stall_b_level", blk_level, 4);
    chk("stall_b_busy", busy, 1);
    blk_ready = 1;
    settle("depth");

    // a new key waits behind queued blocks
    key_ready = 1;
    tick();
    key_ready = 0;
    chk("key_consumed", key_valid, 0);
    blk_ready = 0;
    send(16'hD000, 16'hD001, 16'hD002, 16'hD003, 8'd6, 8'h00, 1);
    send(16'hE000, 16'hE001, 16'hE002, 16'hE003, 8'd7, 8'h20, 1);
    repeat (5) tick();
    chk("keywait_valid", key_valid, 0);
    chk("keywait_busy", busy, 1);
    chk("keywait_level", blk_level, 1);
    blk_ready = 1;
    begin
      int g = 0;
      while (!key_valid && g < 20) begin tick(); g++; end
      if (g >= 20) timeout("keywait");
    end
    chk("keywait_loaded", key, 64'hE003_E002_E001_E000);
    chk("keywait_fifo", blk_level, 0);

    // sequence count wraps 255 -> 0 without error
    for (int i = 0; i < 260; i++)
      send(16'(i), 16'(i) ^ 16'hFFFF, 16'h5A00 + 16'(i), 16'hC3C3 ^ 16'(i), 8'(8 + i), 8'h00, 1);
    settle("wrap");
    chk("wrap_no_err", err_total, 4);

    // reset while a two-block packet sits in BLK_B
    blk_ready = 0;
    send(16'hF000, 16'hF001, 16'hF002, 16'hF003, 8'd12, 8'h80, 0);
    tick(); tick();
    chk("mid_level", blk_level, 1);
    chk("mid_busy", busy, 1);
    nR = 0;
    #1;
    reset_vals("midreset");
    tick();
    nR = 1;
    tick();
    blk_ready = 1;
    send(16'h7000, 16'h7001, 16'h7002, 16'h7003, 8'd0, 8'h00, 1);
    settle("after_reset");
    chk("after_reset_err", err_total, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
